prefetch_unit: RTL and testbench
================================

PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single core clock; all state on rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port cs, input, 16 bits: current code segment, taken directly from the segment register file CS port.
REQ-004 SHALL have port load_new_ip, input, 1 bit: single-cycle pulse to redirect fetch (jump, call, far transfer, CS write).
REQ-005 SHALL have port new_ip, input, 16 bits: new fetch offset, valid with load_new_ip.
REQ-006 SHALL have port mem_access, output, 1 bit: instruction-memory request.
REQ-007 SHALL have port mem_address, output, 19 bits: word address, physical bits [19:1].
REQ-008 SHALL have port mem_ack, input, 1 bit: request complete; mem_data valid this cycle.
REQ-009 SHALL have port mem_data, input, 16 bits: fetched word, little-endian.
REQ-010 SHALL have port fifo_rd_en, input, 1 bit: consumer pops the head byte.
REQ-011 SHALL have port fifo_rd_data, output, 8 bits: head byte, show-ahead.
REQ-012 SHALL have port fifo_empty, output, 1 bit: no valid byte.
REQ-013 SHALL have port fifo_count, output, 3 bits: valid bytes, 0..6.

Function
REQ-014 SHALL hold a 6-byte circular queue and a 16-bit fetch_ip.
REQ-015 SHALL use states IDLE, FETCH and ABORT.
REQ-016 IDLE->FETCH when the queue has space for the request: free >= 2 for even fetch_ip, free >= 1 for odd fetch_ip.
REQ-017 SHALL latch address ({cs,4'b0} + fetch_ip) mod 2^20 on FETCH entry, drive bits [19:1], and hold address and mem_access high until mem_ack.
REQ-018 On mem_ack in FETCH:
- even fetch_ip: push mem_data[7:0] then [15:0]'s [15:8]; fetch_ip += 2.
- odd fetch_ip: push mem_data[15:8] only; fetch_ip += 1.
- Return to IDLE; fetch_ip wraps modulo 2^16.
REQ-019 mem_access SHALL be low in IDLE; minimum one IDLE cycle between requests.
REQ-020 load_new_ip in IDLE or FETCH SHALL, next cycle:
- empty the queue (count 0);
- set fetch_ip = new_ip;
- go to ABORT if the access is outstanding without mem_ack this cycle, else IDLE.
REQ-021 ABORT SHALL keep mem_access high until mem_ack, discard the data, then go to IDLE.
REQ-022 load_new_ip with mem_ack in the same cycle SHALL discard the data.
REQ-023 load_new_ip in ABORT SHALL update fetch_ip and remain in ABORT.
REQ-024 fifo_rd_en SHALL be ignored when fifo_empty.
REQ-025 Pop and push in the same cycle SHALL both take effect.
REQ-026 load_new_ip with fifo_rd_en: flush wins.
REQ-027 First request after load_new_ip at cycle N SHALL assert mem_access at N+2, from IDLE.
REQ-028 A cs change without load_new_ip SHALL NOT affect an in-flight request.

Reset
REQ-029 reset_n low SHALL immediately force:
- state IDLE, mem_access 0, mem_address 0;
- fetch_ip 0, fifo_count 0, fifo_empty 1, fifo_rd_data 0.
REQ-030 Reset mid-access SHALL drop mem_access asynchronously and abandon the access; a late mem_ack after reset SHALL be ignored.

Configuration
REQ-031 Macro PREFETCH_BYPASS_EN defined: with the queue empty, in FETCH with mem_ack and no load_new_ip, the block SHALL:
- present the first pushed byte on fifo_rd_data in the same cycle;
- drive fifo_empty low in the same cycle;
- when fifo_rd_en is also high, consume that byte and not store it.
REQ-032 PREFETCH_BYPASS_EN undefined: fetched bytes SHALL first be visible the cycle after mem_ack.

Verification
REQ-033 cs=0x1000, load new_ip=0x0100, mem_data=0xBBAA ->
- mem_address=0x08080;
- queue holds 0xAA then 0xBB, count 2;
- next request at 0x08081.
REQ-034 new_ip=0x0101, mem_data=0xBBAA ->
- mem_address=0x08080;
- only 0xBB pushed, count 1;
- next mem_address=0x08081.
REQ-035 cs=0xFFFF, new_ip=0x0010 -> mem_address=0x00000 (20-bit wrap); new_ip=0xFFFE -> after fetch, fetch_ip=0x0000.
REQ-036 No pops, mem_ack one cycle after every request -> count reaches 6 after 3 acks; mem_access then stays low until a pop frees 2 bytes.
REQ-037 load_new_ip=0x2000 while a request is pending, mem_ack 3 cycles later ->
- queue empty;
- old data dropped;
- following request addresses {cs,4'b0}+0x2000.
REQ-038 reset_n low mid-FETCH, then mem_ack -> mem_access 0 at once, count 0, nothing pushed.
REQ-039 PREFETCH_BYPASS_EN defined, empty queue, mem_ack with mem_data=0x3412 -> fifo_rd_data=0x12 and fifo_empty=0 in the ack cycle; with the macro undefined, this is visible one cycle later.

Source files
------------

// File: rtl/prefetch_unit_if.sv
// Instruction-fetch bus: memory request/ack side plus the byte-queue consumer side.
// Master is the prefetch unit; slave is the memory/decoder environment.
interface prefetch_unit_if;
  logic        mem_access;
  logic [18:0] mem_address;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        fifo_empty;
  logic [2:0]  fifo_count;

  modport master (
    output mem_access, mem_address, fifo_rd_data, fifo_empty, fifo_count,
    input  mem_ack, mem_data, fifo_rd_en
  );

  modport slave (
    input  mem_access, mem_address, fifo_rd_data, fifo_empty, fifo_count,
    output mem_ack, mem_data, fifo_rd_en
  );
endinterface

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: fetches 16-bit words at cs:fetch_ip into a 6-byte show-ahead queue.
// Latency: request 1 cycle after space appears, bytes visible cycle after mem_ack (same cycle with PREFETCH_BYPASS_EN).
// Backpressure: holds off requests while the queue lacks room for the whole fetch; load_new_ip flushes.
module prefetch_unit (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [15:0]            cs,
  input  logic                   load_new_ip,
  input  logic [15:0]            new_ip,
  prefetch_unit_if.master        bus
);

  localparam logic [2:0] DEPTH = 3'd6;

  typedef enum logic [1:0] {IDLE, FETCH, ABORT} state_t;

  state_t      state;
  logic [15:0] fetch_ip;
  logic [7:0]  q_mem [0:5];
  logic [2:0]  rd_ptr;
  logic [2:0]  wr_ptr;
  logic [2:0]  count;

  logic [18:0] word_addr;
  logic [2:0]  free_bytes;
  logic        req_ok;
  logic        ack_take;
  logic        pop;
  logic        bypass_vld;
  logic        bypass_pop;
  logic [7:0]  first_byte;
  logic [7:0]  second_byte;
  logic [1:0]  push_cnt;
  logic [7:0]  push_b0;
  logic [7:0]  push_b1;

  function automatic logic [2:0] ptr_inc(input logic [2:0] p);
    return (p == 3'd5) ? 3'd0 : p + 3'd1;
  endfunction

  // Word address of cs*16 + fetch_ip; cs*16 is even, so halving splits cleanly.
  assign word_addr   = {cs, 3'b000} + {4'b0000, fetch_ip[15:1]};
  assign free_bytes  = DEPTH - count;
  assign req_ok      = fetch_ip[0] ? (free_bytes >= 3'd1) : (free_bytes >= 3'd2);
  assign ack_take    = (state == FETCH) && bus.mem_ack && !load_new_ip;
  assign first_byte  = fetch_ip[0] ? bus.mem_data[15:8] : bus.mem_data[7:0];
  assign second_byte = bus.mem_data[15:8];

`ifdef PREFETCH_BYPASS_EN
  assign bypass_vld = ack_take && (count == 3'd0);
`else
  assign bypass_vld = 1'b0;
`endif

  assign bypass_pop = bypass_vld && bus.fifo_rd_en;
  assign pop        = bus.fifo_rd_en && (count != 3'd0) && !load_new_ip;

  assign bus.fifo_empty   = (count == 3'd0) && !bypass_vld;
  assign bus.fifo_count   = count;
  assign bus.fifo_rd_data = (count != 3'd0) ? q_mem[rd_ptr] :
                            (bypass_vld ? first_byte : 8'h00);

  // A bypassed byte that is popped in the ack cycle never enters the queue.
  always_comb begin
    push_cnt = 2'd0;
    push_b0  = first_byte;
    push_b1  = second_byte;
    if (ack_take) begin
      if (fetch_ip[0]) begin
        push_cnt = bypass_pop ? 2'd0 : 2'd1;
      end else if (bypass_pop) begin
        push_cnt = 2'd1;
        push_b0  = second_byte;
      end else begin
        push_cnt = 2'd2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) begin
      q_mem[wr_ptr] <= push_b0;
    end
    if (push_cnt == 2'd2) begin
      q_mem[ptr_inc(wr_ptr)] <= push_b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= 3'd0;
      wr_ptr <= 3'd0;
      count  <= 3'd0;
    end else if (load_new_ip) begin
      rd_ptr <= 3'd0;
      wr_ptr <= 3'd0;
      count  <= 3'd0;
    end else begin
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case (push_cnt)
        2'd1:    wr_ptr <= ptr_inc(wr_ptr);
        2'd2:    wr_ptr <= ptr_inc(ptr_inc(wr_ptr));
        default: wr_ptr <= wr_ptr;
      endcase
      count <= count + {1'b0, push_cnt} - {2'b00, pop};
    end
  end

  // Address is latched at request time, so later cs writes never disturb a pending access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      fetch_ip        <= 16'h0000;
      bus.mem_access  <= 1'b0;
      bus.mem_address <= 19'h00000;
    end else begin
      case (state)
        IDLE: begin
          if (load_new_ip) begin
            fetch_ip <= new_ip;
          end else if (req_ok) begin
            state           <= FETCH;
            bus.mem_access  <= 1'b1;
            bus.mem_address <= word_addr;
          end
        end
        FETCH: begin
          if (load_new_ip) begin
            fetch_ip <= new_ip;
            if (bus.mem_ack) begin
              state          <= IDLE;
              bus.mem_access <= 1'b0;
            end else begin
              state <= ABORT;
            end
          end else if (bus.mem_ack) begin
            fetch_ip       <= fetch_ip + (fetch_ip[0] ? 16'd1 : 16'd2);
            state          <= IDLE;
            bus.mem_access <= 1'b0;
          end
        end
        ABORT: begin
          if (load_new_ip) begin
            fetch_ip <= new_ip;
          end
          if (bus.mem_ack) begin
            state          <= IDLE;
            bus.mem_access <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          bus.mem_access <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit: hand-computed addresses, queue contents and flush/abort/reset behaviour.
module tb_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cs;
  logic        load_new_ip;
  logic [15:0] new_ip;

  prefetch_unit_if bus();

  prefetch_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cs          (cs),
    .load_new_ip (load_new_ip),
    .new_ip      (new_ip),
    .bus         (bus)
  );

  always #5 clk = ~clk;

`ifdef PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge and drop the single-cycle strobes.
  task automatic step();
    @(posedge clk);
    #1;
    load_new_ip    = 1'b0;
    bus.mem_ack    = 1'b0;
    bus.fifo_rd_en = 1'b0;
  endtask

  initial begin
    reset_n        = 1'b0;
    cs             = 16'h1000;
    load_new_ip    = 1'b0;
    new_ip         = 16'h0000;
    bus.mem_ack    = 1'b0;
    bus.mem_data   = 16'h0000;
    bus.fifo_rd_en = 1'b0;
    #2;
    check_val("rst_access", 32'(bus.mem_access), 32'h0);
    check_val("rst_addr", 32'(bus.mem_address), 32'h0);
    check_val("rst_count", 32'(bus.fifo_count), 32'h0);
    check_val("rst_empty", 32'(bus.fifo_empty), 32'h1);
    check_val("rst_rdata", 32'(bus.fifo_rd_data), 32'h0);

    // Even fetch: cs=0x1000, ip=0x0100
    step(); reset_n = 1'b1; load_new_ip = 1'b1; new_ip = 16'h0100; #1;
    check_val("load_n0_access", 32'(bus.mem_access), 32'h0);
    step(); #1;
    check_val("load_n1_access", 32'(bus.mem_access), 32'h0);
    step(); #1;
    check_val("load_n2_access", 32'(bus.mem_access), 32'h1);
    check_val("even_addr", 32'(bus.mem_address), 32'h08080);
    step(); bus.mem_ack = 1'b1; bus.mem_data = 16'hBBAA; #1;
    check_val("hold_addr", 32'(bus.mem_address), 32'h08080);
    check_val("ack1_empty", 32'(bus.fifo_empty), BYP ? 32'h0 : 32'h1);
    check_val("ack1_rdata", 32'(bus.fifo_rd_data), BYP ? 32'hAA : 32'h0);
    step(); bus.fifo_rd_en = 1'b1; #1;
    check_val("even_count", 32'(bus.fifo_count), 32'h2);
    check_val("even_head", 32'(bus.fifo_rd_data), 32'hAA);
    check_val("idle_access", 32'(bus.mem_access), 32'h0);
    step(); bus.fifo_rd_en = 1'b1; #1;
    check_val("next_addr", 32'(bus.mem_address), 32'h08081);
    check_val("next_access", 32'(bus.mem_access), 32'h1);
    check_val("pop_head", 32'(bus.fifo_rd_data), 32'hBB);
    check_val("pop_count", 32'(bus.fifo_count), 32'h1);

    // Ack into an empty queue
    step(); bus.mem_ack = 1'b1; bus.mem_data = 16'h3412; #1;
    check_val("byp_empty", 32'(bus.fifo_empty), BYP ? 32'h0 : 32'h1);
    check_val("byp_rdata", 32'(bus.fifo_rd_data), BYP ? 32'h12 : 32'h0);
    step(); #1;
    check_val("byp_late_rdata", 32'(bus.fifo_rd_data), 32'h12);
    check_val("byp_late_count", 32'(bus.fifo_count), 32'h2);

    // Redirect while a request is pending; ack arrives 3 cycles later
    step(); load_new_ip = 1'b1; new_ip = 16'h2000; #1;
    check_val("abort_req_addr", 32'(bus.mem_address), 32'h08082);
    step(); #1;
    check_val("abort_count", 32'(bus.fifo_count), 32'h0);
    check_val("abort_access", 32'(bus.mem_access), 32'h1);
    step();
    step(); bus.mem_ack = 1'b1; bus.mem_data = 16'hDEAD; #1;
    check_val("abort_ack_empty", 32'(bus.fifo_empty), 32'h1);
    step(); #1;
    check_val("abort_done_access", 32'(bus.mem_access), 32'h0);
    check_val("abort_drop_count", 32'(bus.fifo_count), 32'h0);

    // Redirect coinciding with ack: data discarded
    step(); load_new_ip = 1'b1; new_ip = 16'h0101; bus.mem_ack = 1'b1; bus.mem_data = 16'h5555; #1;
    check_val("redirect_addr", 32'(bus.mem_address), 32'h09000);
    check_val("load_ack_empty", 32'(bus.fifo_empty), 32'h1);
    step(); #1;
    check_val("load_ack_access", 32'(bus.mem_access), 32'h0);
    check_val("load_ack_count", 32'(bus.fifo_count), 32'h0);

    // Odd fetch: only the high byte is pushed
    step(); bus.mem_ack = 1'b1; bus.mem_data = 16'hBBAA; #1;
    check_val("odd_addr", 32'(bus.mem_address), 32'h08080);
    step(); load_new_ip = 1'b1; new_ip = 16'h0000; bus.fifo_rd_en = 1'b1; #1;
    check_val("odd_count", 32'(bus.fifo_count), 32'h1);
    check_val("odd_head", 32'(bus.fifo_rd_data), 32'hBB);
    step(); #1;
    check_val("flush_wins_count", 32'(bus.fifo_count), 32'h0);

    // Fill the queue with immediate acks
    step(); bus.mem_ack = 1'b1; bus.mem_data = 16'h1100; #1;
    check_val("fill1_addr", 32'(bus.mem_address), 32'h08000);
    step(); #1;
    check_val("fill1_count", 32'(bus.fifo_count), 32'h2);
    step(); bus.mem_ack = 1'b1; bus.mem_data = 16'h3322; #1;
    check_val("fill2_addr", 32'(bus.mem_address), 32'h08001);
    step();
    step(); bus.mem_ack = 1'b1; bus.mem_data = 16'h5544; #1;
    check_val("fill3_addr", 32'(bus.mem_address), 32'h08002);
    step(); #1;
    check_val("full_count", 32'(bus.fifo_count), 32'h6);
    step(); #1;
    check_val("full_stall", 32'(bus.mem_access), 32'h0);
    step(); bus.fifo_rd_en = 1'b1; #1;
    check_val("full_stall2", 32'(bus.mem_access), 32'h0);
    check_val("full_head", 32'(bus.fifo_rd_data), 32'h00);
    step(); bus.fifo_rd_en = 1'b1; #1;
    check_val("one_free_count", 32'(bus.fifo_count), 32'h5);
    check_val("one_free_stall", 32'(bus.mem_access), 32'h0);
    step(); #1;
    check_val("two_free_count", 32'(bus.fifo_count), 32'h4);
    check_val("two_free_head", 32'(bus.fifo_rd_data), 32'h22);
    check_val("two_free_idle", 32'(bus.mem_access), 32'h0);
    step(); bus.mem_ack = 1'b1; bus.mem_data = 16'h7766; bus.fifo_rd_en = 1'b1; #1;
    check_val("resume_access", 32'(bus.mem_access), 32'h1);
    check_val("resume_addr", 32'(bus.mem_address), 32'h08003);
    step(); cs = 16'hFFFF; load_new_ip = 1'b1; new_ip = 16'h0010; #1;
    check_val("pushpop_count", 32'(bus.fifo_count), 32'h5);
    check_val("pushpop_head", 32'(bus.fifo_rd_data), 32'h33);

    // 20-bit address wrap and 16-bit fetch_ip wrap
    step(); #1;
    check_val("wrap_flush_count", 32'(bus.fifo_count), 32'h0);
    step(); bus.mem_ack = 1'b1; bus.mem_data = 16'h0000; #1;
    check_val("wrap20_access", 32'(bus.mem_access), 32'h1);
    check_val("wrap20_addr", 32'(bus.mem_address), 32'h00000);
    step(); load_new_ip = 1'b1; new_ip = 16'hFFFE;
    step();
    step(); bus.mem_ack = 1'b1; bus.mem_data = 16'hCDAB; #1;
    check_val("ipfffe_addr", 32'(bus.mem_address), 32'h07FF7);
    step(); #1;
    check_val("ipfffe_count", 32'(bus.fifo_count), 32'h2);
    check_val("ipfffe_head", 32'(bus.fifo_rd_data), 32'hAB);
    step(); #1;
    check_val("ipwrap_addr", 32'(bus.mem_address), 32'h7FFF8);
    check_val("ipwrap_access", 32'(bus.mem_access), 32'h1);

    // cs change mid-request, then reset mid-FETCH with a late ack
    step(); cs = 16'h1000; #1;
    check_val("cs_change_addr", 32'(bus.mem_address), 32'h7FFF8);
    reset_n = 1'b0; #1;
    check_val("midrst_access", 32'(bus.mem_access), 32'h0);
    check_val("midrst_count", 32'(bus.fifo_count), 32'h0);
    check_val("midrst_empty", 32'(bus.fifo_empty), 32'h1);
    check_val("midrst_addr", 32'(bus.mem_address), 32'h0);
    check_val("midrst_rdata", 32'(bus.fifo_rd_data), 32'h0);
    step(); reset_n = 1'b1; bus.mem_ack = 1'b1; bus.mem_data = 16'h9999; #1;
    check_val("late_ack_access", 32'(bus.mem_access), 32'h0);
    check_val("late_ack_empty", 32'(bus.fifo_empty), 32'h1);
    step(); bus.fifo_rd_en = 1'b1; #1;
    check_val("late_ack_count", 32'(bus.fifo_count), 32'h0);
    check_val("post_rst_addr", 32'(bus.mem_address), 32'h08000);
    step(); #1;
    check_val("empty_pop_count", 32'(bus.fifo_count), 32'h0);
    check_val("empty_pop_empty", 32'(bus.fifo_empty), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
